spi_byte_master: RTL and testbench



---
 rtl/spi_byte_master_pkg.sv | 19 +
 rtl/spi_byte_master_sclk_gen.sv | 67 ++++++
 rtl/spi_byte_master.sv | 139 +++++++++++++
 tb/tb_spi_byte_master.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_master_pkg.sv
// Shared constants and types for the SPI byte master: mode codes, FSM states
// and the SCLK edge-count terminal value.
package spi_byte_master_pkg;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  localparam int          EDGE_CW       = 5;
  localparam logic [4:0]  EDGE_TERMINAL = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_byte_master_sclk_gen.sv
// SCLK generator: half-bit counter, SCLK toggle and leading/trailing edge
// strobes. Strobes are asserted in the cycle whose closing edge toggles SCLK.
module spi_sclk_gen
  import spi_byte_master_pkg::*;
#(
  parameter logic CPOL = 1'b0,
  parameter int   H    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_clear,
  input  logic               i_run,
  output logic               o_sclk,
  output logic               o_lead,
  output logic               o_trail,
  output logic [EDGE_CW-1:0] o_edge_cnt
);

  localparam int            CW        = (H > 2) ? $clog2(H) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

  logic [CW-1:0]      half_cnt_q, half_cnt_d;
  logic [EDGE_CW-1:0] edge_cnt_q, edge_cnt_d;
  logic               sclk_q, sclk_d;
  logic               wrap_s;

  assign wrap_s     = i_run && (half_cnt_q == HALF_LAST);
  // Toggle number edge_cnt_q+1 is odd (leading) when edge_cnt_q is even.
  assign o_lead     = wrap_s && (edge_cnt_q[0] == 1'b0);
  assign o_trail    = wrap_s && (edge_cnt_q[0] == 1'b1);
  assign o_sclk     = sclk_q;
  assign o_edge_cnt = edge_cnt_q;

  // Next-state for the half-bit counter, edge counter and SCLK level.
  always_comb begin
    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    if (i_clear) begin
      half_cnt_d = '0;
      edge_cnt_d = '0;
      sclk_d     = CPOL;
    end else if (wrap_s) begin
      half_cnt_d = '0;
      edge_cnt_d = edge_cnt_q + 5'd1;
      sclk_d     = ~sclk_q;
    end else if (i_run) begin
      half_cnt_d = half_cnt_q + CW'(1);
    end else begin
      half_cnt_d = half_cnt_q;
    end
  end

  // Counter and SCLK registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      half_cnt_q <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= CPOL;
    end else begin
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Single-byte SPI master: accepts a byte on the tx handshake, shifts it out
// MSB first on MOSI while capturing MISO, then strobes the received byte.
module spi_byte_master
  import spi_byte_master_pkg::*;
#(
  parameter int SPI_MODE          = SPI_MODE0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso
);

  localparam logic [1:0] MODE = SPI_MODE[1:0];
  localparam logic       CPOL = MODE[1];
  localparam logic       CPHA = MODE[0];

  state_e             state_q, state_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               mosi_q, mosi_d;
  logic               tx_ready_q, tx_ready_d;
  logic               rx_dv_q, rx_dv_d;
  logic               accept_s, run_s, lead_s, trail_s, last_s, sample_s, drive_s;
  logic [EDGE_CW-1:0] edge_cnt_s;

  assign accept_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && i_tx_dv;
  assign run_s    = (state_q == ST_SHIFT);
  assign last_s   = trail_s && (edge_cnt_s == (EDGE_TERMINAL - 5'd1));
  assign sample_s = CPHA ? trail_s : lead_s;
  // In CPHA=0 bit 7 is already on MOSI, so the final trailing edge has nothing to advance.
  assign drive_s  = CPHA ? lead_s : (trail_s && !last_s);

  spi_sclk_gen #(
    .CPOL (CPOL),
    .H    (CLKS_PER_HALF_BIT)
  ) u_sclk_gen (
    .clk        (clk),
    .rstn       (rstn),
    .i_clear    (accept_s),
    .i_run      (run_s),
    .o_sclk     (o_sclk),
    .o_lead     (lead_s),
    .o_trail    (trail_s),
    .o_edge_cnt (edge_cnt_s)
  );

  // Handshake FSM and shift-register next-state.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    mosi_d     = mosi_q;
    tx_ready_d = tx_ready_q;
    rx_dv_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_tx_dv) begin
          state_d    = ST_SHIFT;
          tx_ready_d = 1'b0;
          rx_shift_d = 8'h00;
          if (CPHA) begin
            mosi_d     = 1'b0;
            tx_shift_d = i_tx_byte;
          end else begin
            mosi_d     = i_tx_byte[7];
            tx_shift_d = {i_tx_byte[6:0], 1'b0};
          end
        end else begin
          state_d    = ST_IDLE;
          tx_ready_d = 1'b1;
          mosi_d     = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (sample_s) begin
          rx_shift_d = {rx_shift_q[6:0], i_miso};
        end else begin
          rx_shift_d = rx_shift_q;
        end
        if (drive_s) begin
          mosi_d     = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end else begin
          mosi_d     = mosi_q;
        end
        if (last_s) begin
          state_d    = ST_DONE;
          tx_ready_d = 1'b1;
          rx_dv_d    = 1'b1;
          rx_byte_d  = rx_shift_d;
        end else begin
          state_d    = ST_SHIFT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_ready_d = 1'b1;
        mosi_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  assign o_tx_ready = tx_ready_q;
  assign o_rx_byte  = rx_byte_q;
  assign o_rx_dv    = rx_dv_q;
  assign o_mosi     = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: a mode-0/H=2 instance with MISO looped
// to MOSI and a mode-3/H=4 instance talking to a small slave model.
module tb_spi_byte_master;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_byte0 = 8'h00, rx_byte0;
  logic       tx_dv0 = 1'b0, ready0, rx_dv0, sclk0, mosi0, miso0;
  logic [7:0] tx_byte3 = 8'h00, rx_byte3;
  logic       tx_dv3 = 1'b0, ready3, rx_dv3, sclk3, mosi3, miso3;

  int tests = 0;
  int fails = 0;

  logic       sclk_pat [1:80];
  logic       rdy_pat  [1:80];
  logic [7:0] s0_rx   = 8'h00;
  logic [7:0] s3_rx   = 8'h00;
  logic [7:0] s3_byte = 8'h00;
  logic [2:0] lead_cnt;
  logic [2:0] s3_idx;

  spi_byte_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) dut0 (
    .clk(clk), .rstn(rstn), .i_tx_byte(tx_byte0), .i_tx_dv(tx_dv0),
    .o_tx_ready(ready0), .o_rx_byte(rx_byte0), .o_rx_dv(rx_dv0),
    .o_sclk(sclk0), .o_mosi(mosi0), .i_miso(miso0)
  );

  spi_byte_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) dut3 (
    .clk(clk), .rstn(rstn), .i_tx_byte(tx_byte3), .i_tx_dv(tx_dv3),
    .o_tx_ready(ready3), .o_rx_byte(rx_byte3), .o_rx_dv(rx_dv3),
    .o_sclk(sclk3), .o_mosi(mosi3), .i_miso(miso3)
  );

  // Mode 0 slave: loopback, and MOSI captured on rising (leading) SCLK.
  assign miso0 = mosi0;
  always @(posedge sclk0) s0_rx <= {s0_rx[6:0], mosi0};

  // Mode 3 slave: presents next bit after each falling (leading) SCLK, captures on rising.
  always @(negedge sclk3 or negedge rstn) begin
    if (!rstn) lead_cnt <= 3'd0;
    else       lead_cnt <= lead_cnt + 3'd1;
  end
  assign s3_idx = 3'd0 - lead_cnt;
  assign miso3  = s3_byte[s3_idx];
  always @(posedge sclk3) s3_rx <= {s3_rx[6:0], mosi3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n counts negedges after accept edge A: values seen are those clk edge A+n samples.
  task automatic xfer0(input logic [7:0] b, input int ncyc, input int inj_n, input int rst_at,
                       input bit hold, output int toggles, output int dv_cnt, output int dv_at);
    logic prev;
    toggles = 0; dv_cnt = 0; dv_at = 0;
    @(negedge clk);
    @(negedge clk);
    chk("d0_ready_before_request", 32'(ready0), 32'd1);
    tx_byte0 = b;
    tx_dv0   = 1'b1;
    prev     = sclk0;
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) tx_dv0 = 1'b0;
      if (hold && n == ncyc) tx_dv0 = 1'b0;
      if (inj_n != 0 && n == inj_n) begin tx_dv0 = 1'b1; tx_byte0 = 8'hFF; end
      if (inj_n != 0 && n == inj_n + 1) begin tx_dv0 = 1'b0; tx_byte0 = 8'h00; end
      if (rst_at != 0 && n == rst_at) begin
        rstn = 1'b0;
        #1;
        chk("rst_sclk",    32'(sclk0),    32'd0);
        chk("rst_mosi",    32'(mosi0),    32'd0);
        chk("rst_ready",   32'(ready0),   32'd1);
        chk("rst_rx_dv",   32'(rx_dv0),   32'd0);
        chk("rst_rx_byte", 32'(rx_byte0), 32'h00);
      end
      if (rst_at != 0 && n == rst_at + 2) rstn = 1'b1;
      if (sclk0 !== prev) toggles++;
      prev = sclk0;
      if (rx_dv0 === 1'b1) begin dv_cnt++; dv_at = n; end
      if (n <= 80) begin sclk_pat[n] = sclk0; rdy_pat[n] = ready0; end
    end
  endtask

  task automatic xfer3(input logic [7:0] b, input logic [7:0] slave, input int ncyc,
                       output int toggles, output int dv_cnt, output int dv_at);
    logic prev;
    int   w;
    toggles = 0; dv_cnt = 0; dv_at = 0; w = 0;
    @(negedge clk);
    while (ready3 !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("d3_ready_wait", 32'(ready3), 32'd1);
    s3_byte  = slave;
    tx_byte3 = b;
    tx_dv3   = 1'b1;
    prev     = sclk3;
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) tx_dv3 = 1'b0;
      if (n == 2) chk("d3_mosi_before_toggle1", 32'(mosi3), 32'd0);
      if (sclk3 !== prev) toggles++;
      prev = sclk3;
      if (rx_dv3 === 1'b1) begin dv_cnt++; dv_at = n; end
    end
  endtask

  initial begin
    int tg, dc, da, mism, total_dv;
    repeat (3) @(negedge clk);
    chk("reset_sclk0",   32'(sclk0),    32'd0);
    chk("reset_mosi0",   32'(mosi0),    32'd0);
    chk("reset_ready0",  32'(ready0),   32'd1);
    chk("reset_rx_dv0",  32'(rx_dv0),   32'd0);
    chk("reset_rx_byte0",32'(rx_byte0), 32'h00);
    chk("reset_sclk3",   32'(sclk3),    32'd1);
    chk("reset_ready3",  32'(ready3),   32'd1);
    rstn = 1'b1;

    // Mode 0, H=2, loopback 0xA5.
    xfer0(8'hA5, 40, 0, 0, 1'b0, tg, dc, da);
    chk("m0_rx_byte",     32'(rx_byte0),   32'hA5);
    chk("m0_dv_count",    32'(dc),         32'd1);
    chk("m0_dv_at",       32'(da),         32'd33);
    chk("m0_toggles",     32'(tg),         32'd16);
    chk("m0_sclk_idle",   32'(sclk0),      32'd0);
    chk("m0_mosi_idle",   32'(mosi0),      32'd0);
    chk("m0_slave_mosi",  32'(s0_rx),      32'hA5);
    chk("m0_ready_busy",  32'(rdy_pat[1]), 32'd0);
    chk("m0_ready_late",  32'(rdy_pat[32]),32'd0);
    chk("m0_ready_done",  32'(rdy_pat[33]),32'd1);

    // Request of 0xFF at A+10 during a 0x0F transfer is ignored.
    xfer0(8'h0F, 40, 10, 0, 1'b0, tg, dc, da);
    chk("ign_mosi_stream", 32'(s0_rx),    32'h0F);
    chk("ign_rx_byte",     32'(rx_byte0), 32'h0F);
    chk("ign_dv_count",    32'(dc),       32'd1);
    chk("ign_dv_at",       32'(da),       32'd33);

    // Reset mid-byte, then a clean transfer.
    xfer0(8'hC3, 40, 0, 20, 1'b0, tg, dc, da);
    chk("rst_no_dv",        32'(dc),       32'd0);
    chk("rst_rx_byte_held", 32'(rx_byte0), 32'h00);
    xfer0(8'hC3, 40, 0, 0, 1'b0, tg, dc, da);
    chk("post_rst_rx_byte", 32'(rx_byte0), 32'hC3);
    chk("post_rst_dv_at",   32'(da),       32'd33);

    // i_tx_dv held high: accepts at A and A+33 with identical SCLK patterns.
    xfer0(8'h33, 66, 0, 0, 1'b1, tg, dc, da);
    mism = 0;
    for (int n = 1; n <= 33; n++) if (sclk_pat[n] !== sclk_pat[n + 33]) mism++;
    chk("hold_dv_count",    32'(dc),          32'd2);
    chk("hold_dv_at",       32'(da),          32'd66);
    chk("hold_toggles",     32'(tg),          32'd32);
    chk("hold_ready_done",  32'(rdy_pat[33]), 32'd1);
    chk("hold_reaccept",    32'(rdy_pat[34]), 32'd0);
    chk("hold_sclk_repeat", 32'(mism),        32'd0);
    chk("hold_rx_byte",     32'(rx_byte0),    32'h33);

    // Mode 3, H=4: send 0x81, slave returns 0x3C.
    xfer3(8'h81, 8'h3C, 70, tg, dc, da);
    chk("m3_slave_mosi", 32'(s3_rx),    32'h81);
    chk("m3_rx_byte",    32'(rx_byte3), 32'h3C);
    chk("m3_dv_at",      32'(da),       32'd65);
    chk("m3_dv_count",   32'(dc),       32'd1);
    chk("m3_toggles",    32'(tg),       32'd16);
    chk("m3_sclk_idle",  32'(sclk3),    32'd1);
    chk("m3_mosi_idle",  32'(mosi3),    32'd0);

    // Command-processor sequence 0x80, 0x01, 0x00 with slave 0x00, 0x00, 0x5A.
    total_dv = 0;
    xfer3(8'h80, 8'h00, 70, tg, dc, da);
    total_dv += dc;
    chk("cp1_slave_mosi", 32'(s3_rx),    32'h80);
    chk("cp1_rx_byte",    32'(rx_byte3), 32'h00);
    xfer3(8'h01, 8'h00, 70, tg, dc, da);
    total_dv += dc;
    chk("cp2_slave_mosi", 32'(s3_rx),    32'h01);
    xfer3(8'h00, 8'h5A, 70, tg, dc, da);
    total_dv += dc;
    chk("cp3_slave_mosi", 32'(s3_rx),    32'h00);
    chk("cp_final_rx",    32'(rx_byte3), 32'h5A);
    chk("cp_dv_pulses",   32'(total_dv), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
